// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Imported by pwm_channel and pwm_multi.
package pwm_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    // Only edge-aligned counting exists today; centre-aligned is reserved.
    typedef enum logic [0:0] {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTRE = 1'b1
    } pwm_mode_e;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int ch_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty, comparator against the shared
// counter, polarity inversion and output register.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             per_nonzero,
    input  logic [WIDTH-1:0] cnt,
    input  logic             duty_we,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             polarity,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_shadow_reg;
    logic [WIDTH-1:0] duty_active_reg;
    logic             act;

    // Duty >= period naturally yields 100 % because cnt never reaches period.
    assign act = en && per_nonzero && (cnt < duty_active_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow_reg <= '0;
            duty_active_reg <= '0;
            pwm_out         <= 1'b0;
        end else begin
            if (duty_we) begin
                duty_shadow_reg <= duty_in;
            end
            // Active takes the shadow's old value, so a write in a load
            // cycle waits for the next load.
            if (load) begin
                duty_active_reg <= duty_shadow_reg;
            end
            pwm_out <= act ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered period and
// per-channel duty registers, glitch-free updates at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  CHANNELS = DEF_CHANNELS,
    localparam int CH_W     = ch_idx_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                period_we,
    input  logic [WIDTH-1:0]    period_in,
    input  logic                duty_we,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic [CHANNELS-1:0] polarity,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] per_shadow_reg;
    logic [WIDTH-1:0] per_active_reg;
    logic             per_nonzero;
    logic             last_slot;
    logic             load_active;

    always_comb begin
        per_nonzero = |per_active_reg;
        last_slot   = en && per_nonzero && (cnt_reg == per_active_reg - WIDTH'(1));
        // Disabled or zero period both pin the counter and keep the
        // actives tracking the shadows, so re-enable starts fresh.
        load_active = !en || !per_nonzero || last_slot;
        cnt_next    = load_active ? '0 : cnt_reg + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            per_shadow_reg <= '0;
            per_active_reg <= '0;
            period_tick    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            period_tick <= last_slot;
            if (period_we) begin
                per_shadow_reg <= period_in;
            end
            if (load_active) begin
                per_active_reg <= per_shadow_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // Out-of-range channel indices match no instance and are dropped.
            pwm_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .load       (load_active),
                .per_nonzero(per_nonzero),
                .cnt        (cnt_reg),
                .duty_we    (duty_we && (duty_ch == CH_W'(gi))),
                .duty_in    (duty_in),
                .polarity   (polarity[gi]),
                .pwm_out    (pwm_out[gi])
            );
        end
    endgenerate

endmodule
